machine_timer_bank: RTL
=======================

// Module: machine_timer_bank
// PURPOSE
//  Memory-mapped machine timer block with a 64-bit mtime counter, a programmable prescaler and
//  NUM_CHANNELS independent 64-bit compare channels. Each channel runs one-shot (level) or
//  periodic (auto-reload, sticky pending). It sits on the core data bus in the clk24 domain.
//  It drives the core's timer interrupt (mip_mtip) plus one interrupt line per channel.
// PARAMETERS
//  BASE_ADDRESS    32'h80000000  byte address of word 0; must be aligned to a 16-byte boundary
//  NUM_CHANNELS    2             compare channels, 1..8
//  PRESCALE_WIDTH  8             width of the prescale divisor field in CTRL, 1..16
// PORTS
//  clk24                 input   1             core clock; the only clock
//  reset_n               input   1             asynchronous, active-low reset
//  memory_address        input   32            byte address from the core; only bits [31:2] are decoded
//  memory_write_value    input   32            write data, already lane-shifted
//  memory_write_sections input   4             byte enables; 0 means no write
//  read_value            output  32            registered read data
//  read_hit              output  1             registered; 1 when the previous cycle's address decoded here
//  channel_irq           output  NUM_CHANNELS  per-channel interrupt
//  mip_mtip              output  1             OR of channel_irq
// BEHAVIOUR
//  Word map (offset = (memory_address - BASE_ADDRESS) >> 2):
//   0 MTIME_LO   1 MTIME_HI
//   2 CTRL: [0] count_en, [PRESCALE_WIDTH+7:8] divisor
//   3 PENDING: [NUM_CHANNELS-1:0], write-1-to-clear
//   4+4n CMP_LO[n]   5+4n CMP_HI[n]   6+4n PERIOD[n] (32-bit)
//   7+4n CHCTRL[n]: [0] ch_en, [1] periodic
//  Unmapped offsets inside the window read 0 and ignore writes. Unimplemented bits read 0.
//  Reset values:
//   - mtime=0; CTRL count_en=1, divisor=0.
//   - CMP=all ones, PERIOD=0, CHCTRL=0, PENDING=0.
//   - Prescale count=0; read_value=0; read_hit=0; channel_irq=0; mip_mtip=0.
//  Reads: 1-cycle latency, matching block RAM. The address is sampled on edge k; read_value and
//   read_hit are valid after edge k. Outside the window: read_value=0, read_hit=0.
//   Reads have no side effects.
//  Writes: byte-granular per memory_write_sections, committed at the clock edge.
//  Prescaler: when count_en=1, the prescale count increments each cycle.
//   - When count == divisor, the count returns to 0 and mtime += 1.
//   - divisor=0 gives one tick per cycle. mtime wraps 2^64-1 -> 0.
//   - count_en=0 freezes both mtime and the prescale count.
//   - A write to CTRL resets the prescale count to 0.
//  mtime write: in any cycle with a write to word 0 or 1, mtime does not tick. The written bytes
//   load and the other bytes hold. The prescale count still advances.
//  Match: match[n] = ch_en[n] && (mtime >= CMP[n]), an unsigned 64-bit compare on registered values.
//  One-shot (periodic=0): channel_irq[n] = match[n] as a level; PENDING[n] is not used.
//  Periodic (periodic=1): on any cycle with match[n]:
//   - PENDING[n] <= 1 and CMP[n] <= CMP[n] + PERIOD, zero-extended with 64-bit wrap.
//   - channel_irq[n] = PENDING[n].
//   - PERIOD=0 keeps CMP unchanged, so the channel re-matches every cycle; that is legal.
//  channel_irq and mip_mtip are registered: they reflect state one cycle after the match condition.
//  Simultaneous events:
//   - A software write to CMP[n] in the same cycle as an auto-reload: the software bytes win and
//     the unwritten bytes take the reloaded value.
//   - A PENDING W1C in the same cycle as a new periodic match: set wins and PENDING stays 1.
//   - A CHCTRL write clearing ch_en: match is suppressed from the next cycle; PENDING is kept.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous).
//   Release must be synchronised externally.
// TESTING
//  1. Reset, no writes, 10 cycles -> mtime reads 10; mip_mtip=0; read_hit=1 one cycle after the read.
//  2. CTRL divisor=3, count_en=1, 40 cycles -> mtime advances by exactly 10; count_en=0 then freezes it.
//  3. CMP0=20 with ch_en, one-shot -> channel_irq[0] rises at cycle 21.
//     Then writing CMP0=1000 drops it the cycle after the write.
//  4. CMP1=100, PERIOD1=50, periodic -> PENDING1 sets at mtime 100, 150 and 200.
//     W1C clears it between events; a W1C in the same cycle as a match leaves it 1.
//  5. Write MTIME_LO=0xFFFFFFFF, MTIME_HI=0xFFFFFFFF, then 1 tick -> mtime=0.
//     A periodic CMP near 2^64 wraps correctly on reload.
//  6. Assert reset_n low mid-count with PENDING set -> all outputs and registers return to their
//     reset values immediately.

Source files
------------

// File: rtl/machine_timer_bank.sv
// Machine timer bank: 64-bit mtime behind a programmable prescaler, plus NUM_CHANNELS 64-bit
// compare channels (one-shot level or periodic auto-reload), with 1-cycle registered bus reads.
module machine_timer_bank #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
  parameter int          NUM_CHANNELS   = 2,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic                    clk24,
  input  logic                    reset_n,
  input  logic [31:0]             memory_address,
  input  logic [31:0]             memory_write_value,
  input  logic [3:0]              memory_write_sections,
  output logic [31:0]             read_value,
  output logic                    read_hit,
  output logic [NUM_CHANNELS-1:0] channel_irq,
  output logic                    mip_mtip
);
  localparam int NUM_WORDS = 4 + 4 * NUM_CHANNELS;
  localparam int PW        = PRESCALE_WIDTH;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [63:0]             mtime_q, mtime_d;
  logic                    count_en_q, count_en_d;
  logic [PW-1:0]           divisor_q, divisor_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  logic [63:0]             cmp_q    [NUM_CHANNELS];
  logic [63:0]             cmp_d    [NUM_CHANNELS];
  logic [31:0]             period_q [NUM_CHANNELS];
  logic [31:0]             period_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ch_en_q, ch_en_d;
  logic [NUM_CHANNELS-1:0] periodic_q, periodic_d;
  logic [NUM_CHANNELS-1:0] irq_q, irq_d;
  logic                    mtip_q, mtip_d;
  logic [31:0]             read_value_q, read_value_d;
  logic                    read_hit_q, read_hit_d;

  logic [31:0]             addr_diff_s;
  logic [29:0]             word_s;
  logic [29:0]             rel_s;
  logic                    in_window_s;
  logic                    wr_s;
  logic                    tick_s;
  logic [NUM_CHANNELS-1:0] match_s;
  logic [63:0]             reload_s [NUM_CHANNELS];
  logic [31:0]             ctrl_rd_s, ctrl_wr_s, pend_rd_s, rdata_s;
  logic [31:0]             chan_word_s [8][4];
  logic                    unused_s;

  // Addresses below BASE_ADDRESS wrap to huge offsets, so the lower bound is checked explicitly.
  assign addr_diff_s = memory_address - BASE_ADDRESS;
  assign word_s      = addr_diff_s[31:2];
  assign rel_s       = word_s - 30'd4;
  assign in_window_s = (memory_address >= BASE_ADDRESS) && (word_s < 30'(NUM_WORDS));
  assign wr_s        = in_window_s && (memory_write_sections != 4'd0);
  assign pend_rd_s   = 32'(pending_q);
  assign unused_s    = ^{addr_diff_s[1:0], rel_s[29:5], ctrl_wr_s};

  always_comb begin
    ctrl_rd_s          = 32'd0;
    ctrl_rd_s[0]       = count_en_q;
    ctrl_rd_s[PW+7:8]  = divisor_q;
  end

  // Prescaler, mtime and compare-channel next state; software bytes override reloaded bytes.
  always_comb begin
    tick_s     = 1'b0;
    presc_d    = presc_q;
    count_en_d = count_en_q;
    divisor_d  = divisor_q;
    mtime_d    = mtime_q;
    match_s    = '0;
    pending_d  = pending_q;
    ch_en_d    = ch_en_q;
    periodic_d = periodic_q;
    irq_d      = '0;
    ctrl_wr_s  = merge_bytes(ctrl_rd_s, memory_write_value, memory_write_sections);

    if (count_en_q) begin
      if (presc_q == divisor_q) begin
        presc_d = '0;
        tick_s  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end

    if (wr_s && (word_s == 30'd2)) begin
      presc_d    = '0;
      count_en_d = ctrl_wr_s[0];
      divisor_d  = ctrl_wr_s[PW+7:8];
    end else begin
      count_en_d = count_en_q;
      divisor_d  = divisor_q;
    end

    if (wr_s && (word_s == 30'd0)) begin
      mtime_d = {mtime_q[63:32],
                 merge_bytes(mtime_q[31:0], memory_write_value, memory_write_sections)};
    end else if (wr_s && (word_s == 30'd1)) begin
      mtime_d = {merge_bytes(mtime_q[63:32], memory_write_value, memory_write_sections),
                 mtime_q[31:0]};
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end

    for (int n = 0; n < NUM_CHANNELS; n++) begin
      match_s[n]  = ch_en_q[n] && (mtime_q >= cmp_q[n]);
      reload_s[n] = (match_s[n] && periodic_q[n]) ? (cmp_q[n] + {32'd0, period_q[n]}) : cmp_q[n];

      if (wr_s && (word_s == 30'(4 + 4 * n))) begin
        cmp_d[n] = {reload_s[n][63:32],
                    merge_bytes(reload_s[n][31:0], memory_write_value, memory_write_sections)};
      end else if (wr_s && (word_s == 30'(5 + 4 * n))) begin
        cmp_d[n] = {merge_bytes(reload_s[n][63:32], memory_write_value, memory_write_sections),
                    reload_s[n][31:0]};
      end else begin
        cmp_d[n] = reload_s[n];
      end

      if (wr_s && (word_s == 30'(6 + 4 * n))) begin
        period_d[n] = merge_bytes(period_q[n], memory_write_value, memory_write_sections);
      end else begin
        period_d[n] = period_q[n];
      end

      if (wr_s && (word_s == 30'(7 + 4 * n)) && memory_write_sections[0]) begin
        ch_en_d[n]    = memory_write_value[0];
        periodic_d[n] = memory_write_value[1];
      end else begin
        ch_en_d[n]    = ch_en_q[n];
        periodic_d[n] = periodic_q[n];
      end

      // A new periodic match takes priority over a same-cycle W1C.
      if (match_s[n] && periodic_q[n]) begin
        pending_d[n] = 1'b1;
      end else if (wr_s && (word_s == 30'd3) && memory_write_sections[0] && memory_write_value[n]) begin
        pending_d[n] = 1'b0;
      end else begin
        pending_d[n] = pending_q[n];
      end

      irq_d[n] = periodic_q[n] ? pending_d[n] : match_s[n];
    end

    mtip_d = |irq_d;
  end

  // Read data mux; channel words are laid out four per channel starting at word 4.
  always_comb begin
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        chan_word_s[c][k] = 32'd0;
      end
    end
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      chan_word_s[n][0] = cmp_q[n][31:0];
      chan_word_s[n][1] = cmp_q[n][63:32];
      chan_word_s[n][2] = period_q[n];
      chan_word_s[n][3] = {30'd0, periodic_q[n], ch_en_q[n]};
    end
    case (word_s)
      30'd0:   rdata_s = mtime_q[31:0];
      30'd1:   rdata_s = mtime_q[63:32];
      30'd2:   rdata_s = ctrl_rd_s;
      30'd3:   rdata_s = pend_rd_s;
      default: rdata_s = chan_word_s[rel_s[4:2]][rel_s[1:0]];
    endcase
    if (in_window_s) begin
      read_value_d = rdata_s;
      read_hit_d   = 1'b1;
    end else begin
      read_value_d = 32'd0;
      read_hit_d   = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q      <= 64'd0;
      count_en_q   <= 1'b1;
      divisor_q    <= '0;
      presc_q      <= '0;
      pending_q    <= '0;
      ch_en_q      <= '0;
      periodic_q   <= '0;
      irq_q        <= '0;
      mtip_q       <= 1'b0;
      read_value_q <= 32'd0;
      read_hit_q   <= 1'b0;
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        cmp_q[n]    <= '1;
        period_q[n] <= 32'd0;
      end
    end else begin
      mtime_q      <= mtime_d;
      count_en_q   <= count_en_d;
      divisor_q    <= divisor_d;
      presc_q      <= presc_d;
      pending_q    <= pending_d;
      ch_en_q      <= ch_en_d;
      periodic_q   <= periodic_d;
      irq_q        <= irq_d;
      mtip_q       <= mtip_d;
      read_value_q <= read_value_d;
      read_hit_q   <= read_hit_d;
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        cmp_q[n]    <= cmp_d[n];
        period_q[n] <= period_d[n];
      end
    end
  end

  assign read_value  = read_value_q;
  assign read_hit    = read_hit_q;
  assign channel_irq = irq_q;
  assign mip_mtip    = mtip_q;

endmodule
